// File: rtl/dmac_arb_pkg.sv
// Shared types and the winner-selection function for the DMA request arbiter.
// pick_winner works on an 8-bit vector so any channel count up to eight can use it.
package dmac_arb_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_OFFER   = 2'd1,
        ARB_ACTIVE  = 2'd2,
        ARB_RELEASE = 2'd3
    } arb_state_t;

    // Promoted pending channels take precedence; within a pool the highest index wins.
    function automatic logic [2:0] pick_winner(input logic [MAX_CH-1:0] req,
                                               input logic [MAX_CH-1:0] promoted);
        logic [MAX_CH-1:0] pool;
        logic [2:0]        idx;
        pool = ((req & promoted) != 8'd0) ? (req & promoted) : req;
        idx  = 3'd0;
        for (int i = 0; i < MAX_CH; i++) begin
            if (pool[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/dmac_req_sync.sv
// Multi-flop synchroniser bringing the asynchronous peripheral request levels
// into the clk domain; every flop clears on reset.
module dmac_req_sync #(
    parameter int N_CH        = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] async_in,
    output logic [N_CH-1:0] sync_out
);

    logic [N_CH-1:0] stage_r [SYNC_STAGES];

    // Shift chain: stage 0 samples the raw line, the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                stage_r[i] <= '0;
            end
        end else begin
            stage_r[0] <= async_in;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                stage_r[i] <= stage_r[i-1];
            end
        end
    end

    assign sync_out = stage_r[SYNC_STAGES-1];

endmodule

// File: rtl/dmac_req_arbiter.sv
// DMA request front-end: synchronises peripheral requests, picks one channel with
// anti-starvation promotion, offers it by valid/ready and holds it until done.
module dmac_req_arbiter
    import dmac_arb_pkg::*;
#(
    parameter int N_CH         = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int STARVE_LIMIT = 3,
    parameter int CNT_W        = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           dmac_req,
    input  logic                      sel_ready,
    input  logic [N_CH-1:0]           ch_done,
    output logic                      sel_valid,
    output logic [$clog2(N_CH)-1:0]   sel_ch,
    output logic [N_CH-1:0]           sel_onehot,
    output logic [N_CH-1:0]           req_ack,
    output logic                      busy
);

    localparam int                CH_W      = $clog2(N_CH);
    localparam bit                PROMO_EN  = (STARVE_LIMIT != 0);
    localparam logic [CNT_W-1:0]  STARVE_C  = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [N_CH-1:0]   ONE_C     = {{(N_CH-1){1'b0}}, 1'b1};

    arb_state_t        state_r, state_next_s;
    logic [N_CH-1:0]   req_s;
    logic [N_CH-1:0]   promoted_s;
    logic [2:0]        winner_idx_s;
    logic [N_CH-1:0]   win_onehot_s;
    logic [CH_W-1:0]   sel_ch_r, sel_ch_next_s;
    logic [N_CH-1:0]   sel_onehot_r, sel_onehot_next_s;
    logic              sel_valid_r, busy_r;
    logic [CNT_W-1:0]  cnt_r [N_CH];
    logic [CNT_W-1:0]  cnt_next_s [N_CH];
    logic [N_CH-1:0]   req_ack_s;

    dmac_req_sync #(
        .N_CH        (N_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (dmac_req),
        .sync_out (req_s)
    );

    // A channel is promoted once it has lost STARVE_LIMIT arbitrations in a row.
    always_comb begin
        promoted_s = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (PROMO_EN && (cnt_r[i] >= STARVE_C)) begin
                promoted_s[i] = 1'b1;
            end else begin
                promoted_s[i] = 1'b0;
            end
        end
        winner_idx_s = pick_winner(8'(req_s), 8'(promoted_s));
        win_onehot_s = ONE_C << winner_idx_s;
    end

    // Next-state, next-selection and starvation-counter update.
    always_comb begin
        state_next_s      = state_r;
        sel_ch_next_s     = sel_ch_r;
        sel_onehot_next_s = sel_onehot_r;
        for (int i = 0; i < N_CH; i++) begin
            cnt_next_s[i] = cnt_r[i];
        end

        case (state_r)
            ARB_IDLE: begin
                sel_onehot_next_s = '0;
                if (req_s != '0) begin
                    state_next_s      = ARB_OFFER;
                    sel_ch_next_s     = winner_idx_s[CH_W-1:0];
                    sel_onehot_next_s = win_onehot_s;
                    for (int i = 0; i < N_CH; i++) begin
                        if (win_onehot_s[i]) begin
                            cnt_next_s[i] = '0;
                        end else if (req_s[i] && (cnt_r[i] != CNT_MAX)) begin
                            cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                        end else begin
                            cnt_next_s[i] = cnt_r[i];
                        end
                    end
                end else begin
                    state_next_s = ARB_IDLE;
                end
            end
            ARB_OFFER: begin
                // Acceptance outranks a withdrawal seen in the same cycle.
                if (sel_ready) begin
                    state_next_s = ARB_ACTIVE;
                end else if (!req_s[sel_ch_r]) begin
                    state_next_s      = ARB_IDLE;
                    sel_onehot_next_s = '0;
                end else begin
                    state_next_s = ARB_OFFER;
                end
            end
            ARB_ACTIVE: begin
                if (ch_done[sel_ch_r]) begin
                    state_next_s      = ARB_RELEASE;
                    sel_onehot_next_s = '0;
                end else begin
                    state_next_s = ARB_ACTIVE;
                end
            end
            ARB_RELEASE: begin
                state_next_s      = ARB_IDLE;
                sel_onehot_next_s = '0;
            end
            default: begin
                state_next_s      = ARB_IDLE;
                sel_onehot_next_s = '0;
            end
        endcase
    end

    // State, registered outputs and counters; outputs track the next state so they are flop-driven.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ARB_IDLE;
            sel_ch_r     <= '0;
            sel_onehot_r <= '0;
            sel_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= '0;
            end
        end else begin
            state_r      <= state_next_s;
            sel_ch_r     <= sel_ch_next_s;
            sel_onehot_r <= sel_onehot_next_s;
            sel_valid_r  <= (state_next_s == ARB_OFFER);
            busy_r       <= (state_next_s != ARB_IDLE);
            for (int i = 0; i < N_CH; i++) begin
                cnt_r[i] <= cnt_next_s[i];
            end
        end
    end

    // Acknowledge is a same-cycle decode of the accepted offer.
    always_comb begin
        req_ack_s = '0;
        if ((state_r == ARB_OFFER) && sel_ready) begin
            req_ack_s = sel_onehot_r;
        end else begin
            req_ack_s = '0;
        end
    end

    assign sel_valid  = sel_valid_r;
    assign sel_ch     = sel_ch_r;
    assign sel_onehot = sel_onehot_r;
    assign busy       = busy_r;
    assign req_ack    = req_ack_s;

endmodule

// File: tb/tb_dmac_req_arbiter.sv
// Directed self-checking bench for dmac_req_arbiter (N_CH=2, SYNC_STAGES=2, STARVE_LIMIT=3).
module tb_dmac_req_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dmac_req;
    logic       sel_ready;
    logic [1:0] ch_done;
    logic       sel_valid;
    logic [0:0] sel_ch;
    logic [1:0] sel_onehot;
    logic [1:0] req_ack;
    logic       busy;

    int n_cmp  = 0;
    int n_fail = 0;

    dmac_req_arbiter #(
        .N_CH         (2),
        .SYNC_STAGES  (2),
        .STARVE_LIMIT (3),
        .CNT_W        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .dmac_req   (dmac_req),
        .sel_ready  (sel_ready),
        .ch_done    (ch_done),
        .sel_valid  (sel_valid),
        .sel_ch     (sel_ch),
        .sel_onehot (sel_onehot),
        .req_ack    (req_ack),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst = 1'b0; dmac_req = 2'b00; sel_ready = 1'b0; ch_done = 2'b00;
        tick; tick;
        rst = 1'b1;
    endtask

    task automatic wait_offer(output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (sel_valid === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; dmac_req = 2'b00; sel_ready = 1'b0; ch_done = 2'b00;
        tick; tick;
        n_cmp++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h exp=0", sel_valid); end
        n_cmp++; if (sel_ch !== 1'b0) begin n_fail++; $display("FAIL rst_ch got=%0h exp=0", sel_ch); end
        n_cmp++; if (sel_onehot !== 2'b00) begin n_fail++; $display("FAIL rst_onehot got=%0h exp=0", sel_onehot); end
        n_cmp++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL rst_ack got=%0h exp=0", req_ack); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", busy); end
        rst = 1'b1;
        tick; tick;
        n_cmp++; if ({sel_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rst_idle got=%0h exp=0", {sel_valid, busy}); end
    endtask

    task automatic test_single;
        apply_reset;
        dmac_req = 2'b01;
        tick; tick;
        n_cmp++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL single_early got=%0h exp=0", sel_valid); end
        tick;
        n_cmp++; if (sel_valid !== 1'b1) begin n_fail++; $display("FAIL single_lat3 got=%0h exp=1", sel_valid); end
        n_cmp++; if (sel_ch !== 1'b0) begin n_fail++; $display("FAIL single_ch got=%0h exp=0", sel_ch); end
        n_cmp++; if (sel_onehot !== 2'b01) begin n_fail++; $display("FAIL single_onehot got=%0h exp=1", sel_onehot); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%0h exp=1", busy); end
        sel_ready = 1'b1;
        #1;
        n_cmp++; if (req_ack !== 2'b01) begin n_fail++; $display("FAIL single_ack got=%0h exp=1", req_ack); end
        tick;
        n_cmp++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_once got=%0h exp=0", req_ack); end
        sel_ready = 1'b0;
        n_cmp++; if ({sel_valid, busy, sel_onehot} !== 4'b0101) begin n_fail++; $display("FAIL single_active got=%0h exp=5", {sel_valid, busy, sel_onehot}); end
        dmac_req = 2'b00;
        ch_done = 2'b01;
        tick;
        ch_done = 2'b00;
        n_cmp++; if ({busy, sel_onehot} !== 3'b100) begin n_fail++; $display("FAIL single_release got=%0h exp=4", {busy, sel_onehot}); end
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_lat got=%0h exp=0", busy); end
    endtask

    task automatic test_contention;
        bit to;
        apply_reset;
        dmac_req = 2'b11;
        wait_offer(to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL cont_timeout1 got=%0h exp=0", to); end
        n_cmp++; if ({sel_ch, sel_onehot} !== 3'b110) begin n_fail++; $display("FAIL cont_win1 got=%0h exp=6", {sel_ch, sel_onehot}); end
        sel_ready = 1'b1;
        #1;
        n_cmp++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL cont_ack got=%0h exp=2", req_ack); end
        tick;
        sel_ready = 1'b0;
        ch_done = 2'b10;
        tick;
        ch_done = 2'b00;
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle got=%0h exp=0", busy); end
        wait_offer(to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL cont_timeout2 got=%0h exp=0", to); end
        n_cmp++; if (sel_ch !== 1'b1) begin n_fail++; $display("FAIL cont_win2 got=%0h exp=1", sel_ch); end
    endtask

    task automatic test_starvation;
        bit         to;
        logic [4:0] exp_tbl;
        logic       exp_ch;
        logic [1:0] exp_oh;
        exp_tbl = 5'b10111;
        apply_reset;
        dmac_req = 2'b11;
        for (int k = 0; k < 5; k++) begin
            exp_ch = exp_tbl[k];
            exp_oh = 2'b01 << exp_ch;
            wait_offer(to);
            n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL starve_timeout[%0d] got=%0h exp=0", k, to); end
            n_cmp++; if (sel_ch !== exp_ch) begin n_fail++; $display("FAIL starve_win[%0d] got=%0h exp=%0h", k, sel_ch, exp_ch); end
            sel_ready = 1'b1;
            #1;
            n_cmp++; if (req_ack !== exp_oh) begin n_fail++; $display("FAIL starve_ack[%0d] got=%0h exp=%0h", k, req_ack, exp_oh); end
            tick;
            sel_ready = 1'b0;
            ch_done = exp_oh;
            tick;
            ch_done = 2'b00;
        end
    endtask

    task automatic test_withdraw;
        bit to;
        bit ack_seen;
        apply_reset;
        dmac_req = 2'b10;
        wait_offer(to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL wd_timeout got=%0h exp=0", to); end
        n_cmp++; if (sel_ch !== 1'b1) begin n_fail++; $display("FAIL wd_ch got=%0h exp=1", sel_ch); end
        dmac_req = 2'b00;
        ack_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (req_ack !== 2'b00) ack_seen = 1'b1;
            tick;
            if (i == 0) begin
                n_cmp++; if (sel_valid !== 1'b1) begin n_fail++; $display("FAIL wd_hold got=%0h exp=1", sel_valid); end
            end
            if (i == 2) begin
                n_cmp++; if (sel_valid !== 1'b0) begin n_fail++; $display("FAIL wd_drop got=%0h exp=0", sel_valid); end
            end
        end
        n_cmp++; if (ack_seen !== 1'b0) begin n_fail++; $display("FAIL wd_no_ack got=%0h exp=0", ack_seen); end
        n_cmp++; if ({busy, sel_onehot} !== 3'b000) begin n_fail++; $display("FAIL wd_idle got=%0h exp=0", {busy, sel_onehot}); end
    endtask

    task automatic test_handshake_edges;
        apply_reset;
        sel_ready = 1'b1;
        tick; tick; tick;
        n_cmp++; if ({sel_valid, busy, req_ack} !== 4'b0000) begin n_fail++; $display("FAIL hs_idle_ready got=%0h exp=0", {sel_valid, busy, req_ack}); end
        dmac_req = 2'b10;
        tick; tick;
        n_cmp++; if (req_ack !== 2'b00) begin n_fail++; $display("FAIL hs_idle_pending got=%0h exp=0", req_ack); end
        tick;
        n_cmp++; if (req_ack !== 2'b10) begin n_fail++; $display("FAIL hs_offer_ack got=%0h exp=2", req_ack); end
        tick;
        sel_ready = 1'b0;
        ch_done = 2'b01;
        tick;
        ch_done = 2'b00;
        n_cmp++; if ({busy, sel_valid, sel_onehot} !== 4'b1010) begin n_fail++; $display("FAIL hs_wrong_done got=%0h exp=a", {busy, sel_valid, sel_onehot}); end
        tick;
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL hs_still_busy got=%0h exp=1", busy); end
        dmac_req = 2'b00;
        ch_done = 2'b10;
        tick;
        ch_done = 2'b00;
        n_cmp++; if ({busy, sel_onehot} !== 3'b100) begin n_fail++; $display("FAIL hs_release got=%0h exp=4", {busy, sel_onehot}); end
        tick;
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL hs_done got=%0h exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        bit to;
        apply_reset;
        dmac_req = 2'b01;
        wait_offer(to);
        n_cmp++; if (to !== 1'b0) begin n_fail++; $display("FAIL rm_timeout got=%0h exp=0", to); end
        sel_ready = 1'b1;
        tick;
        sel_ready = 1'b0;
        n_cmp++; if ({busy, sel_onehot} !== 3'b101) begin n_fail++; $display("FAIL rm_active got=%0h exp=5", {busy, sel_onehot}); end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++; if ({sel_valid, sel_ch, sel_onehot, req_ack, busy} !== 7'd0) begin n_fail++; $display("FAIL rm_async got=%0h exp=0", {sel_valid, sel_ch, sel_onehot, req_ack, busy}); end
        tick; tick;
        rst = 1'b1;
        tick; tick;
        n_cmp++; if ({sel_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL rm_early got=%0h exp=0", {sel_valid, busy}); end
        tick;
        n_cmp++; if ({sel_valid, sel_ch} !== 2'b10) begin n_fail++; $display("FAIL rm_reoffer got=%0h exp=2", {sel_valid, sel_ch}); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_starvation;
        test_withdraw;
        test_handshake_edges;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
